// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with trap/eret path and circular return-address stack
module pc_gen #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VEC = 32'h0000_1C00,
  parameter int STEP = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [2:0]       NPCOp,
  input  logic [WIDTH-1:0] npc,
  input  logic             call,
  input  logic [WIDTH-1:0] link_addr,
  input  logic             ret,
  input  logic             trap,
  input  logic [WIDTH-1:0] trap_pc,
  input  logic             eret,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, top;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [AW-1:0] tp_q, tp_d, wi;
  logic [CW-1:0] cnt_q, cnt_d;
  logic unf_q, unf_d, empty, act, do_call, do_ret, push, pop, rep;
  always_comb begin
    empty = cnt_q == '0;
    act = !trap && !eret && !stall;
    do_call = act && call;
    do_ret = act && ret;
    push = do_call && (!do_ret || empty);
    pop = do_ret && !do_call && !empty;
    rep = do_call && do_ret && !empty;
    top = ras_q[tp_q];
    pc_d = trap ? TRAP_VEC : eret ? epc_q : stall ? pc_q : ret ? (empty ? npc : top) :
           (call || |NPCOp) ? npc : pc_q + WIDTH'(STEP);
    epc_d = trap ? trap_pc : epc_q;
    tp_d = push ? tp_q + 1'b1 : pop ? tp_q - 1'b1 : tp_q;
    cnt_d = push ? (cnt_q == FULL ? cnt_q : cnt_q + 1'b1) : pop ? cnt_q - 1'b1 : cnt_q;
    unf_d = unf_q || (do_ret && empty);
    wi = push ? tp_q + 1'b1 : tp_q;
    ras_d = ras_q;
    if (push || rep) ras_d[wi] = link_addr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VEC;
      epc_q <= '0;
      tp_q <= '0;
      cnt_q <= '0;
      unf_q <= 1'b0;
      ras_q <= '{default: '0};
    end else begin
      pc_q <= pc_d;
      epc_q <= epc_d;
      tp_q <= tp_d;
      cnt_q <= cnt_d;
      unf_q <= unf_d;
      ras_q <= ras_d;
    end
  end
  assign PC = pc_q;
  assign epc = epc_q;
  assign ras_empty = empty;
  assign ras_full = cnt_q == FULL;
  assign ras_underflow = unf_q;
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined CPU fetch stage. It replaces the single-redirect PC register: width, reset and trap vectors are generic, and it adds a trap/exception-return path with a saved EPC and a small circular return-address stack (RAS) for call/return redirects. It sits ahead of instruction memory and takes redirect requests from decode/execute (NPCOp, call, ret) and from the exception unit (trap, eret).

## Interface
- WIDTH, 32, PC/address width in bits.
- RESET_VEC, 32'h0000_0000, PC value after reset.
- TRAP_VEC, 32'h0000_1C00, PC loaded on trap.
- STEP, 4, sequential increment.
- RAS_DEPTH, 4, return-address-stack entries; power of two, ≥2.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC; suppresses sequential, NPCOp, call and ret updates.
- NPCOp  in  3  3'b000 = sequential, any other value = redirect to npc.
- npc  in  WIDTH  redirect target for NPCOp, call, and the ret-on-empty fallback.
- call  in  1  redirect to npc and push link_addr onto the RAS.
- link_addr  in  WIDTH  return address pushed by call.
- ret  in  1  redirect to RAS top and pop.
- trap  in  1  exception: PC <= TRAP_VEC, EPC <= trap_pc.
- trap_pc  in  WIDTH  faulting PC to save.
- eret  in  1  exception return: PC <= EPC.
- PC  out  WIDTH  current fetch PC (registered).
- epc  out  WIDTH  saved exception PC (registered).
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_underflow  out  1  sticky; set by ret on an empty RAS.

## Operation
- Next-PC priority, highest first:
  1. trap: PC <= TRAP_VEC, epc <= trap_pc.
  2. eret: PC <= epc.
  3. stall: PC holds.
  4. ret: PC <= RAS top, or npc if the RAS is empty.
  5. call: PC <= npc.
  6. NPCOp != 0: PC <= npc.
  7. Otherwise PC <= PC + STEP.
- trap and eret override stall. All other updates wait for stall = 0.
- When trap and eret are asserted together, trap wins and eret is ignored.
- RAS is a circular buffer with top pointer tp and count cnt (0..RAS_DEPTH).
- RAS is updated only when the selected action is call or ret, i.e. not when trap, eret or stall is active.
- Push: tp <= tp+1 mod RAS_DEPTH, write link_addr at the new tp, cnt <= min(cnt+1, RAS_DEPTH). When full, this silently overwrites the oldest entry.
- Pop on a non-empty RAS: target = entry[tp], tp <= tp-1, cnt <= cnt-1.
- Pop on an empty RAS: target = npc, tp and cnt unchanged, ras_underflow <= 1.
- call and ret in the same cycle: PC <= entry[tp] (npc if empty), then entry[tp] <= link_addr. tp and cnt are unchanged.
  - If the RAS was empty in that case, perform a push instead (cnt becomes 1) and set ras_underflow.
- The RAS is unaffected by trap and eret.
- ras_underflow clears only on reset.
- Arithmetic is modulo 2^WIDTH: PC + STEP wraps from all-ones to 0. Low address bits are not forced or checked.

## Timing
- Every state change happens on the rising clk edge. No combinational path from inputs to PC or epc.
- The redirect takes effect on the PC value in the cycle after the request is sampled, giving one-cycle latency.
- ras_empty and ras_full are decoded from the registered cnt, so they are valid in the cycle after a push or pop.
- Reset values (rst_n low, asynchronous, held for its duration):
  - PC = RESET_VEC, epc = 0.
  - tp = 0, cnt = 0, all RAS entries = 0.
  - ras_empty = 1, ras_full = 0, ras_underflow = 0.
- Reset asserted mid-redirect discards the request. The first edge after deassertion produces RESET_VEC + STEP unless a redirect input is active.

## Test plan
- Reset then free-run, no requests: PC = 0, 4, 8, 12 on successive edges. With stall high for 2 cycles, PC holds at 12 and then goes to 16.
- NPCOp = 3'b001, npc = 0x100 with stall high: PC holds. Drop stall: PC = 0x100, then 0x104.
- Calls with link_addr 0x10, 0x20, 0x30, 0x40, 0x50 (DEPTH 4): ras_full after the 4th call. Then 4 rets: PC = 0x50, 0x40, 0x30, 0x20, then ras_empty = 1. A 5th ret with npc = 0x900: PC = 0x900 and ras_underflow = 1 (sticky).
- trap with trap_pc = 0x2C while stall is high: PC = 0x1C00, epc = 0x2C. Next, eret: PC = 0x2C. trap and eret asserted together: PC = TRAP_VEC.
- RAS holds 0x10, 0x20; call + ret together with link_addr 0x77: PC = 0x20, cnt stays 2. Next ret: PC = 0x77. Next ret: PC = 0x10.
- Wrap-around: reset with RESET_VEC = 32'hFFFF_FFFC; the next edge gives PC = 0.
